// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling ratio and the
// clock-divisor helper used by both the receive and transmit paths.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Integer-truncated clocks per tick; os=16 for rx, os=1 for tx.
  function automatic int uart_div(input int clk_freq, input int baud, input int os);
    return clk_freq / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running divider issuing a one-clock tick every DIV clocks.
// Never re-phased, so the receiver tolerates up to one tick of start-edge jitter.
module uart_baud_gen #(
  parameter int DIV = 325
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Next-count and tick decode.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (cnt_q == LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d  = cnt_q + CW'(1);
      tick_d = 1'b0;
    end
  end

  // Divider and tick registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled serial line to N-bit word with parity and
// stop-bit checking, returning to IDLE at mid-stop so back-to-back frames work.
module uart_rx
  import uart_pkg::*;
#(
  parameter int N         = 8,
  parameter int M         = 1,
  parameter int PARITY_EN = 0,
  parameter int BAUD_RATE = 9600,
  parameter int CLK_FREQ  = 50000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rx,
  output logic [N-1:0] data_out,
  output logic         rx_done,
  output logic         parity_err,
  output logic         frame_err,
  output logic         busy
);

  localparam int DIV = uart_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int BW  = $clog2(((N > M) ? N : M) + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(N - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(M - 1);

  logic          tick;
  logic [1:0]    sync_q, sync_d;
  logic          rxs;
  uart_state_e   state_q, state_d;
  logic [3:0]    tcnt_q, tcnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [N-1:0]  shift_q, shift_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic          armed_q, armed_d;
  logic [N-1:0]  data_out_q, data_out_d;
  logic          rx_done_q, rx_done_d;
  logic          parity_err_q, parity_err_d;
  logic          frame_err_q, frame_err_d;
  logic          busy_q, busy_d;

  uart_baud_gen #(.DIV(DIV)) u_baud_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign rxs = sync_q[1];

  // Synchroniser shift, FSM next state, datapath and output register inputs.
  always_comb begin
    sync_d       = {sync_q[0], rx};
    state_d      = state_q;
    tcnt_d       = tcnt_q;
    bcnt_d       = bcnt_q;
    shift_d      = shift_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    armed_d      = armed_q;
    data_out_d   = data_out_q;
    rx_done_d    = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    case (state_q)
      IDLE: begin
        armed_d = armed_q | rxs;
        if (armed_q && !rxs) begin
          state_d = START;
          tcnt_d  = 4'd0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (tick && (tcnt_q == 4'd7)) begin
          if (!rxs) begin
            state_d = DATA;
            tcnt_d  = 4'd0;
            bcnt_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (tick) begin
          tcnt_d = tcnt_q + 4'd1;
        end else begin
          tcnt_d = tcnt_q;
        end
      end
      DATA: begin
        if (tick) begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == 4'd15) begin
            shift_d = {rxs, shift_q[N-1:1]};
            if (bcnt_q == LAST_DATA) begin
              bcnt_d  = '0;
              state_d = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bcnt_d = bcnt_q + BW'(1);
            end
          end else begin
            shift_d = shift_q;
          end
        end else begin
          tcnt_d = tcnt_q;
        end
      end
      PARITY: begin
        if (tick) begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == 4'd15) begin
            perr_d  = (^shift_q) ^ rxs;
            state_d = STOP;
          end else begin
            perr_d = perr_q;
          end
        end else begin
          tcnt_d = tcnt_q;
        end
      end
      STOP: begin
        if (tick) begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == 4'd15) begin
            ferr_d = ferr_q | ~rxs;
            if (bcnt_q == LAST_STOP) begin
              // Frame ends at mid-stop; a framing error disarms until the line idles high.
              state_d      = IDLE;
              bcnt_d       = '0;
              armed_d      = ~(ferr_q | ~rxs);
              rx_done_d    = 1'b1;
              data_out_d   = shift_q;
              parity_err_d = perr_q;
              frame_err_d  = ferr_q | ~rxs;
            end else begin
              bcnt_d = bcnt_q + BW'(1);
            end
          end else begin
            ferr_d = ferr_q;
          end
        end else begin
          tcnt_d = tcnt_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q       <= 2'b11;
      state_q      <= IDLE;
      tcnt_q       <= 4'd0;
      bcnt_q       <= '0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      armed_q      <= 1'b1;
      data_out_q   <= '0;
      rx_done_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      tcnt_q       <= tcnt_d;
      bcnt_q       <= bcnt_d;
      shift_q      <= shift_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      armed_q      <= armed_d;
      data_out_q   <= data_out_d;
      rx_done_q    <= rx_done_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign data_out   = data_out_q;
  assign rx_done    = rx_done_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: an 8N1 and an 8E2 receiver driven by bit-accurate serial
// frames, checked against a frame-level model of data, parity and stop rules.
module tb_uart_rx;

  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 25000;
  localparam int BIT      = CLK_FREQ / BAUD;  // 64 clocks per bit

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       rx0   = 1'b1;
  logic       rx1   = 1'b1;
  logic [7:0] data0, data1;
  logic       done0, done1, perr0, perr1, ferr0, ferr1, busy0, busy1;

  int n_checks   = 0;
  int n_errors   = 0;
  int cnt0       = 0;
  int cnt1       = 0;
  int busy_clks0 = 0;

  always #5 clk = ~clk;

  uart_rx #(.N(8), .M(1), .PARITY_EN(0), .BAUD_RATE(BAUD), .CLK_FREQ(CLK_FREQ)) dut0 (
    .clk(clk), .reset(reset), .rx(rx0), .data_out(data0), .rx_done(done0),
    .parity_err(perr0), .frame_err(ferr0), .busy(busy0)
  );

  uart_rx #(.N(8), .M(2), .PARITY_EN(1), .BAUD_RATE(BAUD), .CLK_FREQ(CLK_FREQ)) dut1 (
    .clk(clk), .reset(reset), .rx(rx1), .data_out(data1), .rx_done(done1),
    .parity_err(perr1), .frame_err(ferr1), .busy(busy1)
  );

  // Frame-completion and busy-cycle counters.
  always @(negedge clk) begin
    if (done0) cnt0++;
    if (done1) cnt1++;
    if (busy0) busy_clks0++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_rx(input int ch, input logic v);
    if (ch == 0) rx0 = v;
    else rx1 = v;
  endtask

  task automatic hold(input int ch, input logic v, input int n);
    set_rx(ch, v);
    repeat (n) @(negedge clk);
  endtask

  // ch0 frames: start, 8 data, 1 stop. ch1 frames: start, 8 data, parity, 2 stops.
  task automatic send_frame(input int ch, input logic [7:0] b, input logic par, input logic [1:0] stops);
    hold(ch, 1'b0, BIT);
    for (int i = 0; i < 8; i++) hold(ch, b[i], BIT);
    if (ch == 1) begin
      hold(ch, par, BIT);
      hold(ch, stops[0], BIT);
      hold(ch, stops[1], BIT);
    end else begin
      hold(ch, stops[0], BIT);
    end
  endtask

  // Expected {frame_err, parity_err, data}: even parity over data+parity bit, every stop must be 1.
  function automatic logic [9:0] model_frame(input int ch, input logic [7:0] b, input logic par,
                                             input logic [1:0] stops);
    logic p, f;
    if (ch == 1) begin
      p = ((($countones(b) + int'(par)) % 2) != 0);
      f = (stops != 2'b11);
    end else begin
      p = 1'b0;
      f = (stops[0] != 1'b1);
    end
    return {f, p, b};
  endfunction

  task automatic expect_frame(input int ch, input string tag, input int c_before, input logic [9:0] exp);
    int c;
    logic [7:0] d;
    logic pe, fe;
    if (ch == 0) begin c = cnt0; d = data0; pe = perr0; fe = ferr0; end
    else begin c = cnt1; d = data1; pe = perr1; fe = ferr1; end
    check_eq({tag, "_count"}, c, c_before + 1);
    check_eq({tag, "_data"}, d, exp[7:0]);
    check_eq({tag, "_perr"}, pe, exp[8]);
    check_eq({tag, "_ferr"}, fe, exp[9]);
  endtask

  initial begin
    int c, b0, gap, len;
    logic [7:0] b, d;
    logic par;
    logic [1:0] st;

    repeat (5) @(negedge clk);
    check_eq("reset_outs0", {data0, done0, perr0, ferr0, busy0}, 32'd0);
    check_eq("reset_outs1", {data1, done1, perr1, ferr1, busy1}, 32'd0);
    reset = 1'b1;
    hold(0, 1'b1, 2 * BIT);

    // Single clean 8N1 frame.
    c = cnt0; b0 = busy_clks0;
    send_frame(0, 8'h55, 1'b0, 2'b11);
    expect_frame(0, "t1", c, model_frame(0, 8'h55, 1'b0, 2'b11));
    check_eq("t1_busy_seen", busy_clks0 > b0, 32'd1);
    hold(0, 1'b1, BIT);
    check_eq("t1_busy_fall", busy0, 32'd0);

    // Back-to-back frames with no idle gap.
    c = cnt0;
    send_frame(0, 8'hAA, 1'b0, 2'b11);
    expect_frame(0, "t2a", c, model_frame(0, 8'hAA, 1'b0, 2'b11));
    send_frame(0, 8'hCC, 1'b0, 2'b11);
    expect_frame(0, "t2b", c + 1, model_frame(0, 8'hCC, 1'b0, 2'b11));
    hold(0, 1'b1, BIT);

    // Start glitches shorter than half a bit.
    for (int k = 0; k < 4; k++) begin
      c = cnt0; d = data0;
      len = $urandom_range(8, 20);
      hold(0, 1'b0, len);
      check_eq("t3_busy_rise", busy0, 32'd1);
      hold(0, 1'b1, 2 * BIT);
      check_eq("t3_busy_fall", busy0, 32'd0);
      check_eq("t3_no_done", cnt0, c);
      check_eq("t3_data_held", data0, d);
    end

    // Break: stop bit low and line held low.
    c = cnt0;
    send_frame(0, 8'h3C, 1'b0, 2'b00);
    hold(0, 1'b0, 3 * BIT);
    expect_frame(0, "t4", c, model_frame(0, 8'h3C, 1'b0, 2'b00));
    hold(0, 1'b1, 12 * BIT);
    check_eq("t4_no_second", cnt0, c + 1);
    c = cnt0;
    send_frame(0, 8'h5A, 1'b0, 2'b11);
    expect_frame(0, "t4_clean", c, model_frame(0, 8'h5A, 1'b0, 2'b11));
    hold(0, 1'b1, BIT);

    // Parity on the 8E2 receiver.
    c = cnt1;
    send_frame(1, 8'h3C, 1'b1, 2'b11);
    expect_frame(1, "t5_bad", c, model_frame(1, 8'h3C, 1'b1, 2'b11));
    hold(1, 1'b1, BIT);
    c = cnt1;
    send_frame(1, 8'h3C, 1'b0, 2'b11);
    expect_frame(1, "t5_good", c, model_frame(1, 8'h3C, 1'b0, 2'b11));
    hold(1, 1'b1, BIT);

    // Random 8N1 traffic, including zero-gap frames.
    for (int k = 0; k < 20; k++) begin
      b = 8'($urandom);
      st = ($urandom_range(0, 5) == 0) ? 2'b00 : 2'b11;
      c = cnt0;
      send_frame(0, b, 1'b0, st);
      expect_frame(0, "rnd0", c, model_frame(0, b, 1'b0, st));
      gap = (st[0] == 1'b0) ? 8 + $urandom_range(0, 30) : $urandom_range(0, 30);
      hold(0, 1'b1, gap);
    end
    hold(0, 1'b1, BIT);

    // Random 8E2 traffic with injected parity and stop errors.
    for (int k = 0; k < 16; k++) begin
      b = 8'($urandom);
      par = ^b;
      if ($urandom_range(0, 2) == 0) par = ~par;
      st = 2'b11;
      if ($urandom_range(0, 3) == 0) st[$urandom_range(0, 1)] = 1'b0;
      c = cnt1;
      send_frame(1, b, par, st);
      expect_frame(1, "rnd1", c, model_frame(1, b, par, st));
      gap = (st != 2'b11) ? 8 + $urandom_range(0, 30) : $urandom_range(0, 30);
      hold(1, 1'b1, gap);
    end
    hold(1, 1'b1, BIT);

    // Reset pulsed during bit 4 of a 0xF0 frame, then a clean 0x81.
    c = cnt0;
    hold(0, 1'b0, BIT);
    for (int i = 0; i < 4; i++) hold(0, 1'b0, BIT);
    hold(0, 1'b1, 20);
    check_eq("t6_busy_mid", busy0, 32'd1);
    reset = 1'b0;
    #1;
    check_eq("t6_outs0", {data0, done0, perr0, ferr0, busy0}, 32'd0);
    check_eq("t6_outs1", {data1, done1, perr1, ferr1, busy1}, 32'd0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    hold(0, 1'b1, 5 * BIT - 25);
    check_eq("t6_discarded", cnt0, c);
    c = cnt0;
    send_frame(0, 8'h81, 1'b0, 2'b11);
    expect_frame(0, "t6_clean", c, model_frame(0, 8'h81, 1'b0, 2'b11));
    hold(0, 1'b1, BIT);
    check_eq("t6_busy_fall", busy0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
